rv_ctrl_pipe: RTL
=================

Name: rv_ctrl_pipe

Overview:
Next-generation control path: decodes full RV32I opcodes, plus optional M-extension, from a 32-bit instruction. The decoded control bundle is registered into the ID/EX boundary with a valid/ready handshake. Adds load-use hazard stalling, branch flush and an illegal-instruction flag. Sits between the IF/ID register and the execute stage; replaces the 7-signal combinational decoder.

Parameters:
ILEN, 32, instruction width; only 32 supported, and other values are an elaboration error.
REG_ADDR_W, 5, register index width.
ALU_OP_W, 3, width of alu_op_o.
SUPPORT_M, 0, 1 decodes the M-extension (R-type, funct7=0000001); 0 flags it illegal.

Ports:
clk_i  in  1  clock.
rst_n_i  in  1  synchronous active-low reset.
in_valid_i  in  1  instr_i valid.
in_ready_o  out  1  block accepts instr_i this cycle.
instr_i  in  ILEN  instruction from IF/ID.
flush_i  in  1  branch/jump redirect; kills stage contents and input.
out_valid_o  out  1  registered bundle valid.
out_ready_i  in  1  execute stage accepts bundle.
branch_o, jump_o, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_o, reg_write_o  out  1 each  registered controls.
alu_op_o  out  ALU_OP_W  000 add, 001 branch compare, 010 R funct, 011 I funct, 100 pass-B (lui), 101 M-op.
rs1_o, rs2_o, rd_o  out  REG_ADDR_W each  registered register indices.
illegal_o  out  1  registered: unsupported opcode/funct.

Behaviour:
- Reset (rst_n_i=0 at posedge): out_valid_o=0. All control outputs, alu_op_o, indices and illegal_o are 0. Reset mid-stall drops the pending instruction.
- Decode table (opcode -> br,jmp,mr,mw,m2r,src,rw,alu_op):
  - R 0110011: 0,0,0,0,0,0,1,010.
  - I-ALU 0010011: 0,0,0,0,0,1,1,011.
  - load 0000011: 0,0,1,0,1,1,1,000.
  - store 0100011: 0,0,0,1,0,1,0,000.
  - branch 1100011: 1,0,0,0,0,0,0,001.
  - jal 1101111: 0,1,0,0,0,0,1,000.
  - jalr 1100111: 0,1,0,0,0,1,1,000.
  - lui 0110111: 0,0,0,0,0,1,1,100.
  - auipc 0010111: 0,0,0,0,0,1,1,000.
- Any other opcode sets illegal_o=1 with all other controls 0. R-type funct7 other than 0000000 or 0100000 is also illegal; 0000001 is legal only when SUPPORT_M=1, with alu_op=101.
- Register use:
  - uses_rs1 = all opcodes except lui/auipc/jal.
  - uses_rs2 = R, store, branch.
  - Store and branch drive rd_o=0.
- Stage advance: the register loads when (!out_valid_o | out_ready_i). Latency is 1 cycle from the accept edge.
- in_ready_o = stage_advance & !hazard & !flush_i (combinational).
- hazard = out_valid_o & mem_read_o & rd_o!=0 & in_valid_i & ((uses_rs1 & rs1==rd_o) | (uses_rs2 & rs2==rd_o)).
- On hazard with stage_advance: load a bubble (out_valid_o=0). The instruction is accepted the next cycle, giving exactly a 1-cycle stall.
- If out_valid_o=1 and out_ready_i=0, the bundle holds stable; valid must not drop.
- flush_i=1: next edge out_valid_o=0 regardless of out_ready_i; the input is not accepted. flush_i has priority over hazard and stall.
- Illegal instructions flow through as valid bundles with illegal_o=1 and reg_write_o=0.

Decomposition:
- Shared package rv_pkg: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), ALU_OP_* encodings, funct7 constants.
- One combinational sub-module rv_ctrl_dec (instr in -> control bundle, uses_rs1/2, illegal). The top holds the pipeline register, handshake and hazard logic.

Test Plan:
- Reset: hold rst_n_i=0 for 3 cycles with in_valid_i=1 -> out_valid_o=0 and all outputs 0. First valid add x3,x1,x2 (0x002081B3) -> next cycle out_valid_o=1, reg_write_o=1, alu_op_o=010, rd_o=3.
- Load-use: lw x5,0(x1) (0x0000A283) then add x6,x5,x2 -> in_ready_o=0 for 1 cycle, one bubble (out_valid_o=0), then add issued. Same sequence using rd=x0 -> no stall.
- Backpressure: out_ready_i=0 for 4 cycles with sw issued -> bundle stable (mem_write_o=1, rd_o=0), in_ready_o=0. Release -> next instruction follows in 1 cycle.
- Flush: flush_i=1 while out_valid_o=1, out_ready_i=0 and in_valid_i=1 -> next cycle out_valid_o=0, input not consumed.
- Illegal/M: opcode 0x7F -> illegal_o=1, reg_write_o=0. mul (0x022081B3): SUPPORT_M=0 -> illegal_o=1; SUPPORT_M=1 -> alu_op_o=101, illegal_o=0.
- Coverage: all 9 opcodes with random back-to-back valid/ready -> outputs match the decode table, no lost or duplicated instructions.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I/M opcode, funct7 and control-bundle definitions
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] ALU_OP_ADD    = 3'b000;
  localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
  localparam logic [2:0] ALU_OP_RFN    = 3'b010;
  localparam logic [2:0] ALU_OP_IFN    = 3'b011;
  localparam logic [2:0] ALU_OP_PASSB  = 3'b100;
  localparam logic [2:0] ALU_OP_MUL    = 3'b101;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
  } ctrl_t;

  // flags are ordered br,jmp,mr,mw,m2r,src,rw so table rows read left to right
  function automatic ctrl_t mk_ctrl(input logic [6:0] flags, input logic [2:0] op);
    return ctrl_t'({flags, op});
  endfunction

endpackage

// File: rtl/rv_ctrl_dec.sv
// rtl/rv_ctrl_dec.sv - combinational RV32I(+M) opcode decoder producing the control bundle
module rv_ctrl_dec
  import rv_pkg::*;
#(
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        illegal,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       unused_funct3;

  assign opcode        = instr[6:0];
  assign funct7        = instr[31:25];
  assign unused_funct3 = ^instr[14:12];
  assign rs1           = instr[19:15];
  assign rs2           = instr[24:20];

  always_comb begin
    ctrl     = '0;
    illegal  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (funct7 == F7_BASE || funct7 == F7_ALT)
          ctrl = mk_ctrl(7'b0000001, ALU_OP_RFN);
        else if (SUPPORT_M && funct7 == F7_MULDIV)
          ctrl = mk_ctrl(7'b0000001, ALU_OP_MUL);
        else
          illegal = 1'b1;
      end
      OP_IMM: begin
        uses_rs1 = 1'b1;
        ctrl     = mk_ctrl(7'b0000011, ALU_OP_IFN);
      end
      OP_LOAD: begin
        uses_rs1 = 1'b1;
        ctrl     = mk_ctrl(7'b0010111, ALU_OP_ADD);
      end
      OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        ctrl     = mk_ctrl(7'b0001010, ALU_OP_ADD);
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        ctrl     = mk_ctrl(7'b1000000, ALU_OP_BRANCH);
      end
      OP_JAL:   ctrl = mk_ctrl(7'b0100001, ALU_OP_ADD);
      OP_JALR: begin
        uses_rs1 = 1'b1;
        ctrl     = mk_ctrl(7'b0100011, ALU_OP_ADD);
      end
      OP_LUI:   ctrl = mk_ctrl(7'b0000011, ALU_OP_PASSB);
      OP_AUIPC: ctrl = mk_ctrl(7'b0000011, ALU_OP_ADD);
      default:  illegal = 1'b1;
    endcase
    // an illegal instruction reads nothing, so it can never trigger a load-use stall
    if (illegal) begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

  assign rd = (illegal || opcode == OP_STORE || opcode == OP_BRANCH) ? 5'd0 : instr[11:7];

endmodule

// File: rtl/rv_ctrl_pipe.sv
// rtl/rv_ctrl_pipe.sv - decode stage with registered ID/EX bundle, load-use stall and flush
module rv_ctrl_pipe
  import rv_pkg::*;
#(
  parameter int ILEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 3,
  parameter int SUPPORT_M  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ILEN-1:0]       instr_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  branch_o,
  output logic                  jump_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  mem_to_reg_o,
  output logic                  alu_src_o,
  output logic                  reg_write_o,
  output logic [ALU_OP_W-1:0]   alu_op_o,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  illegal_o
);

  if (ILEN != 32) begin : g_ilen_check
    $error("rv_ctrl_pipe supports only ILEN=32");
  end

  ctrl_t      dec_ctrl;
  logic       dec_uses_rs1;
  logic       dec_uses_rs2;
  logic       dec_illegal;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic [4:0] dec_rd;

  ctrl_t      q_ctrl;
  logic       stage_advance;
  logic       hazard;

  rv_ctrl_dec #(
    .SUPPORT_M (SUPPORT_M != 0)
  ) u_dec (
    .instr    (instr_i),
    .ctrl     (dec_ctrl),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .illegal  (dec_illegal),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd)
  );

  assign stage_advance = !out_valid_o || out_ready_i;

  // a load still in ID/EX cannot forward yet, so a dependent instruction waits one cycle
  assign hazard = out_valid_o && mem_read_o && (rd_o != '0) && in_valid_i &&
                  ((dec_uses_rs1 && (REG_ADDR_W'(dec_rs1) == rd_o)) ||
                   (dec_uses_rs2 && (REG_ADDR_W'(dec_rs2) == rd_o)));

  assign in_ready_o = stage_advance && !hazard && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      q_ctrl      <= '0;
      illegal_o   <= 1'b0;
      rs1_o       <= '0;
      rs2_o       <= '0;
      rd_o        <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (stage_advance) begin
      if (in_valid_i && !hazard) begin
        out_valid_o <= 1'b1;
        q_ctrl      <= dec_ctrl;
        illegal_o   <= dec_illegal;
        rs1_o       <= REG_ADDR_W'(dec_rs1);
        rs2_o       <= REG_ADDR_W'(dec_rs2);
        rd_o        <= REG_ADDR_W'(dec_rd);
      end else begin
        out_valid_o <= 1'b0;
      end
    end
  end

  assign branch_o     = q_ctrl.branch;
  assign jump_o       = q_ctrl.jump;
  assign mem_read_o   = q_ctrl.mem_read;
  assign mem_write_o  = q_ctrl.mem_write;
  assign mem_to_reg_o = q_ctrl.mem_to_reg;
  assign alu_src_o    = q_ctrl.alu_src;
  assign reg_write_o  = q_ctrl.reg_write;
  assign alu_op_o     = ALU_OP_W'(q_ctrl.alu_op);

endmodule
